// File: rtl/i2c_init_sequencer.sv
// Walks a table of I2C register writes after start, issuing each entry as one
// write transaction through an I2C controller's enable/ready handshake.
module i2c_init_sequencer #(
    parameter int NUM_ENTRIES    = 16,
    parameter int IDX_W          = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int GAP_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IDX_W-1:0] tbl_index,
    input  logic [15:0]      tbl_entry,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] fail_index,
    output logic             i2c_enable,
    output logic             i2c_mode,
    output logic [6:0]       i2c_periph_addr,
    output logic [7:0]       i2c_transmit_byte,
    input  logic             i2c_ready
);

    // One counter serves hold, gap and timeout since those phases never overlap.
    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_CNT = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        HOLD,
        WAIT_DONE,
        GAP,
        FINISH,
        ERROR
    } state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] index_n, fail_n;
    logic             busy_n, done_n, error_n, enable_n;
    logic [6:0]       addr_n;
    logic [7:0]       data_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             seen_low, seen_low_n;

    assign i2c_mode = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            tbl_index         <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
            fail_index        <= '0;
            i2c_enable        <= 1'b0;
            i2c_periph_addr   <= '0;
            i2c_transmit_byte <= '0;
            cnt               <= '0;
            seen_low          <= 1'b0;
        end else begin
            state             <= state_n;
            tbl_index         <= index_n;
            busy              <= busy_n;
            done              <= done_n;
            error             <= error_n;
            fail_index        <= fail_n;
            i2c_enable        <= enable_n;
            i2c_periph_addr   <= addr_n;
            i2c_transmit_byte <= data_n;
            cnt               <= cnt_n;
            seen_low          <= seen_low_n;
        end
    end

    always_comb begin
        state_n    = state;
        index_n    = tbl_index;
        busy_n     = busy;
        done_n     = done;
        error_n    = error;
        fail_n     = fail_index;
        enable_n   = i2c_enable;
        addr_n     = i2c_periph_addr;
        data_n     = i2c_transmit_byte;
        cnt_n      = cnt;
        seen_low_n = seen_low;

        case (state)
            IDLE: begin
                if (start) begin
                    index_n = '0;
                    done_n  = 1'b0;
                    error_n = 1'b0;
                    busy_n  = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                addr_n  = tbl_entry[14:8];
                data_n  = tbl_entry[7:0];
                cnt_n   = '0;
                state_n = tbl_entry[15] ? FINISH : ISSUE;
            end
            ISSUE: begin
                if (i2c_ready) begin
                    enable_n   = 1'b1;
                    cnt_n      = '0;
                    seen_low_n = 1'b0;
                    state_n    = HOLD;
                end else if (cnt == TMO_LAST) begin
                    state_n = ERROR;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!i2c_ready) begin
                    seen_low_n = 1'b1;
                end
                if (cnt == HOLD_LAST) begin
                    enable_n = 1'b0;
                    cnt_n    = '0;
                    state_n  = WAIT_DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                // A ready that never dipped low is the idle controller's ~enable echo, not a completion.
                if (i2c_ready && seen_low) begin
                    cnt_n   = '0;
                    state_n = GAP;
                end else begin
                    if (!i2c_ready) begin
                        seen_low_n = 1'b1;
                    end
                    if (cnt == TMO_LAST) begin
                        state_n = ERROR;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    if (tbl_index == LAST_IDX) begin
                        state_n = FINISH;
                    end else begin
                        index_n = tbl_index + 1'b1;
                        state_n = FETCH;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            ERROR: begin
                error_n  = 1'b1;
                fail_n   = tbl_index;
                busy_n   = 1'b0;
                enable_n = 1'b0;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Scoreboard bench for i2c_init_sequencer: a behavioural controller model checks
// each enable pulse against queued table entries plus end-of-run status.
module tb_i2c_init_sequencer;

    localparam int NUM_ENTRIES = 4;
    localparam int IDX_W       = 4;
    localparam int HOLD        = 8;
    localparam int GAP         = 64;
    localparam int TMO         = 64;
    localparam int CTRL_BUSY   = 40;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } txn_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [IDX_W-1:0] tbl_index;
    logic [15:0]      tbl_entry;
    logic             busy, done, error;
    logic [IDX_W-1:0] fail_index;
    logic             i2c_enable, i2c_mode;
    logic [6:0]       i2c_periph_addr;
    logic [7:0]       i2c_transmit_byte;
    logic             i2c_ready;

    logic [15:0] table_mem [16];
    txn_t        sb_q [$];
    int          check_count = 0;
    int          fail_count  = 0;
    int          txn_count   = 0;
    int          ctrl_mode   = 0;
    logic        stuck_en    = 1'b0;
    logic        ctrl_busy   = 1'b0;
    int          ctrl_cnt    = 0;
    logic        prev_en     = 1'b0;
    logic        new_run     = 1'b0;
    int          hi_cnt      = 0;
    int          low_cnt     = 0;

    i2c_init_sequencer #(
        .NUM_ENTRIES(NUM_ENTRIES),
        .IDX_W(IDX_W),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .tbl_index(tbl_index),
        .tbl_entry(tbl_entry),
        .busy(busy),
        .done(done),
        .error(error),
        .fail_index(fail_index),
        .i2c_enable(i2c_enable),
        .i2c_mode(i2c_mode),
        .i2c_periph_addr(i2c_periph_addr),
        .i2c_transmit_byte(i2c_transmit_byte),
        .i2c_ready(i2c_ready)
    );

    always #5 clk = ~clk;

    assign tbl_entry = table_mem[tbl_index];

    // Controller model: mode 0 goes busy for CTRL_BUSY cycles per enable, mode 1 never drops ready.
    assign i2c_ready = (ctrl_mode == 1) ? 1'b1 :
                       (stuck_en && tbl_index == IDX_W'(1)) ? 1'b0 :
                       (!ctrl_busy && !i2c_enable);

    always @(posedge clk) begin
        if (ctrl_mode == 0 && !ctrl_busy && i2c_enable) begin
            ctrl_busy <= 1'b1;
            ctrl_cnt  <= CTRL_BUSY;
        end else if (ctrl_busy) begin
            if (ctrl_cnt > 0) begin
                ctrl_cnt <= ctrl_cnt - 1;
            end else if (!i2c_enable) begin
                ctrl_busy <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Each enable rise is one transaction; compare it against the head of the scoreboard.
    always @(negedge clk) begin
        txn_t exp_txn;
        if (i2c_enable && !prev_en) begin
            txn_count++;
            if (!new_run) begin
                checkOutput("gap_len", 32'(low_cnt >= GAP), 32'd1);
            end
            new_run = 1'b0;
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_txn", 32'd1, 32'd0);
            end else begin
                exp_txn = sb_q.pop_front();
                checkOutput("txn_addr", 32'(i2c_periph_addr), 32'(exp_txn.addr));
                checkOutput("txn_byte", 32'(i2c_transmit_byte), 32'(exp_txn.data));
            end
            hi_cnt = 1;
        end else if (!i2c_enable && prev_en) begin
            checkOutput("enable_width", 32'(hi_cnt), 32'(HOLD));
            low_cnt = 1;
        end else if (i2c_enable) begin
            hi_cnt++;
        end else begin
            low_cnt++;
        end
        prev_en = i2c_enable;
    end

    task automatic applyStimulus(input int n_exp);
        txn_t t;
        for (int i = 0; i < n_exp; i++) begin
            t.addr = table_mem[i][14:8];
            t.data = table_mem[i][7:0];
            sb_q.push_back(t);
        end
        txn_count = 0;
        new_run   = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checkOutput({tag, "_expired"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_index"}, 32'(tbl_index), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_fail_index"}, 32'(fail_index), 32'd0);
        checkOutput({tag, "_enable"}, 32'(i2c_enable), 32'd0);
        checkOutput({tag, "_addr"}, 32'(i2c_periph_addr), 32'd0);
        checkOutput({tag, "_byte"}, 32'(i2c_transmit_byte), 32'd0);
        checkOutput({tag, "_mode"}, 32'(i2c_mode), 32'd1);
    endtask

    task automatic loadTable(input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
        for (int i = 0; i < 16; i++) begin
            table_mem[i] = 16'h8000;
        end
        table_mem[0] = e0;
        table_mem[1] = e1;
        table_mem[2] = e2;
        table_mem[3] = e3;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        loadTable(16'h1A0F, 16'h1A80, 16'h1B55, 16'h8000);
        repeat (3) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;
        @(negedge clk);

        // Nominal three-entry table with end marker, including start-to-enable latency.
        applyStimulus(3);
        checkOutput("latency_e0", 32'(i2c_enable), 32'd0);
        @(negedge clk);
        checkOutput("latency_e1", 32'(i2c_enable), 32'd0);
        @(negedge clk);
        checkOutput("latency_e2", 32'(i2c_enable), 32'd1);
        waitIdle("run1");
        checkOutput("run1_done", 32'(done), 32'd1);
        checkOutput("run1_busy", 32'(busy), 32'd0);
        checkOutput("run1_error", 32'(error), 32'd0);
        checkOutput("run1_index", 32'(tbl_index), 32'd3);
        checkOutput("run1_txns", 32'(txn_count), 32'd3);
        checkOutput("run1_sb_left", 32'(sb_q.size()), 32'd0);

        // Controller stuck not-ready on entry 1 times out in ISSUE.
        stuck_en = 1'b1;
        applyStimulus(1);
        waitIdle("stuck");
        checkOutput("stuck_error", 32'(error), 32'd1);
        checkOutput("stuck_fail_index", 32'(fail_index), 32'd1);
        checkOutput("stuck_enable", 32'(i2c_enable), 32'd0);
        checkOutput("stuck_busy", 32'(busy), 32'd0);
        checkOutput("stuck_done", 32'(done), 32'd0);
        checkOutput("stuck_txns", 32'(txn_count), 32'd1);
        stuck_en = 1'b0;
        applyStimulus(3);
        checkOutput("restart_error_clr", 32'(error), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);
        waitIdle("restart");
        checkOutput("restart_done", 32'(done), 32'd1);
        checkOutput("restart_txns", 32'(txn_count), 32'd3);

        // No end marker: stops after NUM_ENTRIES; a start during HOLD is ignored.
        loadTable(16'h2011, 16'h2122, 16'h2233, 16'h2344);
        applyStimulus(4);
        n = 0;
        while (!i2c_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("hold_reached", 32'(i2c_enable), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("restart_ignored_index", 32'(tbl_index), 32'd0);
        waitIdle("noend");
        checkOutput("noend_done", 32'(done), 32'd1);
        checkOutput("noend_index", 32'(tbl_index), 32'd3);
        checkOutput("noend_txns", 32'(txn_count), 32'd4);
        checkOutput("noend_sb_left", 32'(sb_q.size()), 32'd0);

        // Reset during WAIT_DONE of entry 2, then restart from index 0.
        applyStimulus(4);
        n = 0;
        while (!(tbl_index == IDX_W'(2) && i2c_enable) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_entry2", 32'(i2c_enable), 32'd1);
        n = 0;
        while (i2c_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkResetState("midrun");
        checkOutput("midrun_txns", 32'(txn_count), 32'd3);
        reset = 1'b0;
        sb_q.delete();
        applyStimulus(4);
        checkOutput("rerun_index", 32'(tbl_index), 32'd0);
        checkOutput("rerun_busy", 32'(busy), 32'd1);
        waitIdle("rerun");
        checkOutput("rerun_done", 32'(done), 32'd1);
        checkOutput("rerun_txns", 32'(txn_count), 32'd4);
        checkOutput("rerun_sb_left", 32'(sb_q.size()), 32'd0);

        // Ready never drops low: completion rejected, WAIT_DONE times out.
        ctrl_mode = 1;
        loadTable(16'h1A0F, 16'h1A80, 16'h1B55, 16'h8000);
        applyStimulus(1);
        waitIdle("noglitch");
        checkOutput("noglitch_error", 32'(error), 32'd1);
        checkOutput("noglitch_fail_index", 32'(fail_index), 32'd0);
        checkOutput("noglitch_done", 32'(done), 32'd0);
        checkOutput("noglitch_txns", 32'(txn_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
